ims_job_scheduler: RTL and testbench
====================================

Name: ims_job_scheduler

Overview:
- Shares one inter-month spread engine among N_REQ portfolio requesters using round-robin arbitration.
- For each job it:
  - holds the grant (an external mux uses it to select that requester's tier/position/maturity/charge vectors);
  - drives the engine's active-low run/clear input;
  - waits for the engine's done, with a timeout;
  - returns the 16-bit tier spread charge over a valid/ready result port.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(N_REQ), requester index width
- CLR_CYCLES, 2, cycles the engine is held in clear before each job (>=1)
- TIMEOUT, 64, max RUN cycles before the job is aborted (>=16)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- req  in  N_REQ  level request per requester; a requester clears its bit on the edge where its req_ack bit is 1
- req_ack  out  N_REQ  one-hot, combinational (res_valid & res_ready) at gnt_idx
- gnt_valid  out  1  grant held; external input mux must select gnt_idx
- gnt_idx  out  ID_W  granted requester
- eng_run  out  1  drives engine reset pin; 0 = clear/hold, 1 = run
- eng_done  in  1  engine done (level)
- eng_tsc  in  16  engine TSC result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_tsc  out  16  captured TSC
- res_id  out  ID_W  requester the result belongs to
- res_err  out  1  1 = job timed out, res_tsc forced 16'hFFFF
- busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-low; any assertion, including mid-job, forces:
  - state IDLE, rr_ptr 0;
  - eng_run 0, gnt_valid 0, gnt_idx 0;
  - res_valid 0, res_tsc 0, res_id 0, res_err 0, busy 0;
  - timers 0.
  No partial result is emitted.
- The FSM is registered. States are IDLE, CLEAR, RUN, OUT.
- IDLE:
  - If |req, grant the first set bit searching upward from rr_ptr with wrap.
  - Register gnt_idx, gnt_valid=1, rr_ptr = (grant+1) mod N_REQ.
  - Load clr_cnt = CLR_CYCLES-1 and go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR:
  - eng_run=0 (engine internal state and done cleared).
  - clr_cnt decrements; at 0, load to_cnt=TIMEOUT-1 and go to RUN.
- RUN:
  - eng_run=1.
  - If eng_done: res_tsc<=eng_tsc, res_err<=0, res_id<=gnt_idx, res_valid<=1, go to OUT.
  - Else if to_cnt==0: res_tsc<=16'hFFFF, res_err<=1, res_id<=gnt_idx, res_valid<=1, go to OUT.
  - Else to_cnt decrements.
  - If eng_done and timeout occur in the same cycle, done wins.
- OUT:
  - eng_run=0; gnt_valid stays 1 until the handshake.
  - res_valid stays high and res_tsc/res_id/res_err stay stable until res_valid & res_ready.
  - On the handshake: req_ack[res_id]=1 that cycle; next edge res_valid<=0, gnt_valid<=0, go to IDLE.
- Latency:
  - req seen in IDLE at cycle t: CLEAR t+1..t+CLR_CYCLES, RUN from t+CLR_CYCLES+1.
  - res_valid rises the cycle after eng_done is sampled.
  - Minimum turnaround between grants is 1 IDLE cycle.
- Fairness: a requester that deasserts req before it is granted is simply skipped; req_ack is never pulsed for it.
- rr_ptr advances only on a grant.
- req changes during CLEAR/RUN/OUT are ignored until the next IDLE.
- eng_tsc is 16 bits and captured unmodified; there is no arithmetic on it.

Optional Feature:
- Macro IMS_SCHED_STATS_EN.
- When defined, adds the following outputs:
  - stat_jobs (16): completed non-error jobs.
  - stat_timeouts (8): timed-out jobs.
  - stat_max_lat (8): the maximum RUN cycle count observed.
- All three counters saturate, increment at the OUT handshake, and reset to 0 on reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package ims_pkg:
  - state enum (IDLE/CLEAR/RUN/OUT);
  - TSC_W=16;
  - TSC_ERR_VAL=16'hFFFF;
  - a default TIMEOUT constant.
- Sub-module rr_arbiter (parameter N_REQ) takes inputs req and rr_ptr and produces grant_valid and grant_idx combinationally.
- Timers and FSM stay in the top module.

Test Plan:
- Single job: req=4'b0010, engine model asserts done 12 cycles into RUN with eng_tsc=16'h0123.
  -> gnt_idx=1, eng_run=0 for exactly 2 cycles then 1.
  -> res_valid with res_tsc=0x0123, res_id=1, res_err=0, req_ack=4'b0010 on handshake.
- Round robin: req=4'b1111 held, each requester re-asserting after its ack.
  -> grant order 0,1,2,3,0.
  -> With req=4'b1001 after serving 0, the next grant is 3.
- Backpressure: res_ready=0 for 20 cycles after res_valid.
  -> res_tsc/res_id stable, eng_run=0, no new grant.
  -> Handshake on release, IDLE next cycle.
- Timeout: engine never asserts done.
  -> After 64 RUN cycles, res_valid with res_tsc=0xFFFF, res_err=1.
  -> Done and timeout in the same cycle gives res_err=0.
- Reset mid-RUN: assert reset asynchronously between edges.
  -> All outputs zero immediately, including eng_run=0.
  -> After release, first grant searches from index 0.
- IMS_SCHED_STATS_EN defined: 3 good jobs and 1 timeout.
  -> stat_jobs=3, stat_timeouts=1, stat_max_lat=64.

Source files
------------

// File: rtl/ims_pkg.sv
// Shared types and constants for the inter-month spread job scheduler.
package ims_pkg;

    localparam int TSC_W = 16;
    localparam logic [TSC_W-1:0] TSC_ERR_VAL = 16'hFFFF;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/ims_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or above rr_ptr,
// wrapping around, purely combinational.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int ID_W = $clog2(N_REQ);

    int             k;
    logic [ID_W-1:0] kk;

    // Scan offsets from high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        k           = 0;
        kk          = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = int'(rr_ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            kk = k[ID_W-1:0];
            if (req[kk]) begin
                grant_valid = 1'b1;
                grant_idx   = kk;
            end
        end
    end

endmodule

// File: rtl/ims_job_scheduler.sv
// Round-robin scheduler sharing one spread engine between N_REQ requesters.
// Holds the grant for the whole job, clears then runs the engine, waits
// for done with a timeout and returns the charge over valid/ready.
// Optional statistics counters are enabled with IMS_SCHED_STATS_EN.
module ims_job_scheduler
    import ims_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ID_W       = $clog2(N_REQ),
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] req_ack,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             eng_run,
    input  logic             eng_done,
    input  logic [TSC_W-1:0] eng_tsc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TSC_W-1:0] res_tsc,
    output logic [ID_W-1:0]  res_id,
    output logic             res_err,
    output logic             busy
`ifdef IMS_SCHED_STATS_EN
    ,
    output logic [15:0]      stat_jobs,
    output logic [7:0]       stat_timeouts,
    output logic [7:0]       stat_max_lat
`endif
);

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_next;
    logic [CLR_W-1:0] clr_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             arb_valid;
    logic [ID_W-1:0]  arb_idx;
    logic             hs;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .grant_valid(arb_valid),
        .grant_idx  (arb_idx)
    );

    assign hs      = res_valid & res_ready;
    assign busy    = (state != S_IDLE);
    assign rr_next = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;

    // Acknowledge the owning requester in the handshake cycle only.
    always_comb begin
        req_ack = '0;
        if (hs) req_ack[gnt_idx] = 1'b1;
    end

    // Job FSM with registered grant, engine control and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            eng_run   <= 1'b0;
            res_valid <= 1'b0;
            res_tsc   <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
            clr_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        gnt_valid <= 1'b1;
                        gnt_idx   <= arb_idx;
                        rr_ptr    <= rr_next;
                        clr_cnt   <= CLR_W'(CLR_CYCLES - 1);
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt == '0) begin
                        to_cnt  <= TO_W'(TIMEOUT - 1);
                        eng_run <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    // done has priority over a timeout in the same cycle
                    if (eng_done) begin
                        res_tsc   <= eng_tsc;
                        res_err   <= 1'b0;
                        res_id    <= gnt_idx;
                        res_valid <= 1'b1;
                        eng_run   <= 1'b0;
                        state     <= S_OUT;
                    end else if (to_cnt == '0) begin
                        res_tsc   <= TSC_ERR_VAL;
                        res_err   <= 1'b1;
                        res_id    <= gnt_idx;
                        res_valid <= 1'b1;
                        eng_run   <= 1'b0;
                        state     <= S_OUT;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        gnt_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IMS_SCHED_STATS_EN
    logic [7:0] run_lat;
    logic [7:0] lat_now;
    int         run_cycles;

    // RUN cycles spent by the current job, clamped to the 8-bit counter.
    always_comb begin
        run_cycles = TIMEOUT - int'(to_cnt);
        lat_now    = (run_cycles > 255) ? 8'hFF : 8'(run_cycles);
    end

    // Saturating job statistics, committed when the result is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_jobs     <= '0;
            stat_timeouts <= '0;
            stat_max_lat  <= '0;
            run_lat       <= '0;
        end else begin
            if (state == S_RUN && (eng_done || to_cnt == '0)) run_lat <= lat_now;
            if (hs) begin
                if (res_err) begin
                    if (stat_timeouts != 8'hFF) stat_timeouts <= stat_timeouts + 1'b1;
                end else begin
                    if (stat_jobs != 16'hFFFF) stat_jobs <= stat_jobs + 1'b1;
                end
                if (run_lat > stat_max_lat) stat_max_lat <= run_lat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ims_job_scheduler.sv
// Self-checking bench for ims_job_scheduler: table of jobs with an engine
// model, a result scoreboard, plus reset-in-RUN and backpressure sequences.
module tb_ims_job_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_ack;
    logic        gnt_valid;
    logic [1:0]  gnt_idx;
    logic        eng_run;
    logic        eng_done;
    logic [15:0] eng_tsc;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_tsc;
    logic [1:0]  res_id;
    logic        res_err;
    logic        busy;
`ifdef IMS_SCHED_STATS_EN
    logic [15:0] stat_jobs;
    logic [7:0]  stat_timeouts;
    logic [7:0]  stat_max_lat;
`endif

    ims_job_scheduler #(.N_REQ(4), .CLR_CYCLES(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .req(req), .req_ack(req_ack),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .eng_run(eng_run),
        .eng_done(eng_done), .eng_tsc(eng_tsc), .res_valid(res_valid),
        .res_ready(res_ready), .res_tsc(res_tsc), .res_id(res_id),
        .res_err(res_err), .busy(busy)
`ifdef IMS_SCHED_STATS_EN
        , .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts),
        .stat_max_lat(stat_max_lat)
`endif
    );

    always #5 clk = ~clk;

    // Engine model: raises done on RUN cycle done_at (0 = never).
    int          done_at;
    logic [15:0] tsc_drv;
    logic [7:0]  run_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset)       run_cnt <= '0;
        else if (!eng_run) run_cnt <= '0;
        else              run_cnt <= run_cnt + 8'd1;
    end
    assign eng_done = eng_run && (done_at != 0) && (int'(run_cnt) + 1 >= done_at);
    assign eng_tsc  = tsc_drv;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic summary_and_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] tsc;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Scoreboard: compare every accepted result against the expected queue.
    always @(negedge clk) begin
        if (reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result id=%0d tsc=%0h required=none", res_id, res_tsc);
            end else begin
                mon_e = sb.pop_front();
                chk("res_id",  res_id,  mon_e.id);
                chk("res_tsc", res_tsc, mon_e.tsc);
                chk("res_err", res_err, mon_e.err);
                chk("req_ack", req_ack, 4'b0001 << mon_e.id);
            end
        end
    end

    typedef struct {
        logic [3:0]  req;
        int          done_at;
        logic [15:0] tsc;
        logic [1:0]  exp_id;
        logic [15:0] exp_tsc;
        logic        exp_err;
        int          exp_lat;
        int          hold;
    } vec_t;
    vec_t tbl[11];

    // One job: grant, 2 CLEAR cycles, RUN latency, optional stall, handshake.
    task automatic run_job(input vec_t v);
        int k;
        req     = v.req;
        done_at = v.done_at;
        tsc_drv = v.tsc;
        sb.push_back('{v.exp_id, v.exp_tsc, v.exp_err});
        @(posedge clk); #1;
        chk("grant", {gnt_valid, busy, eng_run, gnt_idx}, {1'b1, 1'b1, 1'b0, v.exp_id});
        req = 4'b1111;
        @(posedge clk); #1;
        chk("clear2", eng_run, 1'b0);
        @(posedge clk); #1;
        chk("run_start", eng_run, 1'b1);
        k = 0;
        while (!res_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!res_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL res_valid_wait actual=none required=within_200_cycles");
            summary_and_stop();
        end
        chk("run_lat", k, v.exp_lat);
        chk("out_eng_run", eng_run, 1'b0);
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            chk("hold", {res_valid, gnt_valid, eng_run, gnt_idx, res_id, res_tsc, res_err, req_ack},
                {1'b1, 1'b1, 1'b0, v.exp_id, v.exp_id, v.exp_tsc, v.exp_err, 4'b0000});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("back_idle", {res_valid, gnt_valid, busy, eng_run, req_ack}, 8'h00);
        req = 4'b0000;
    endtask

    initial begin
        //         req      done  tsc       id    exp_tsc   err   lat hold
        tbl[0]  = '{4'b1111,  5, 16'h1111, 2'd0, 16'h1111, 1'b0,  5, 0};
        tbl[1]  = '{4'b1111,  3, 16'h2222, 2'd1, 16'h2222, 1'b0,  3, 0};
        tbl[2]  = '{4'b1111,  7, 16'hA5A5, 2'd2, 16'hA5A5, 1'b0,  7, 0};
        tbl[3]  = '{4'b1111,  1, 16'h0001, 2'd3, 16'h0001, 1'b0,  1, 0};
        tbl[4]  = '{4'b1111,  2, 16'hBEEF, 2'd0, 16'hBEEF, 1'b0,  2, 0};
        tbl[5]  = '{4'b1001,  4, 16'h0000, 2'd3, 16'h0000, 1'b0,  4, 0};
        tbl[6]  = '{4'b0010, 12, 16'h0123, 2'd1, 16'h0123, 1'b0, 12, 0};
        tbl[7]  = '{4'b0100,  0, 16'h5555, 2'd2, 16'hFFFF, 1'b1, 64, 0};
        tbl[8]  = '{4'b1000, 64, 16'h7777, 2'd3, 16'h7777, 1'b0, 64, 0};
        tbl[9]  = '{4'b0001, 65, 16'h8888, 2'd0, 16'hFFFF, 1'b1, 64, 0};
        tbl[10] = '{4'b0110, 10, 16'hCAFE, 2'd1, 16'hCAFE, 1'b0, 10, 20};

        reset     = 1'b0;
        req       = 4'b0000;
        res_ready = 1'b0;
        done_at   = 0;
        tsc_drv   = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {gnt_valid, gnt_idx, eng_run, res_valid, res_tsc, res_id, res_err, busy, req_ack}, 64'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_req", {busy, gnt_valid}, 2'b00);

        foreach (tbl[i]) run_job(tbl[i]);

`ifdef IMS_SCHED_STATS_EN
        chk("stat_jobs", stat_jobs, 16'd9);
        chk("stat_timeouts", stat_timeouts, 8'd2);
        chk("stat_max_lat", stat_max_lat, 8'd64);
`endif

        // Reset asserted between edges in the middle of RUN.
        req     = 4'b0100;
        done_at = 0;
        @(posedge clk); #1;
        chk("rst_job_grant", {gnt_valid, gnt_idx}, {1'b1, 2'd2});
        req = 4'b0000;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_job_running", eng_run, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset", {gnt_valid, gnt_idx, eng_run, res_valid, res_tsc, res_id, res_err, busy, req_ack}, 64'h0);
`ifdef IMS_SCHED_STATS_EN
        chk("stat_reset", {stat_jobs, stat_timeouts, stat_max_lat}, 32'h0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        // rr_ptr must restart at 0: requesters 1 and 3 pending, 1 wins.
        run_job('{4'b1010, 6, 16'h4321, 2'd1, 16'h4321, 1'b0, 6, 0});
`ifdef IMS_SCHED_STATS_EN
        chk("stat_after_rst", {stat_jobs, stat_timeouts, stat_max_lat}, {16'd1, 8'd0, 8'd6});
`endif
        chk("sb_drained", sb.size(), 0);
        repeat (3) @(posedge clk);
        summary_and_stop();
    end

endmodule
